// File: rtl/dat_mem_sync.sv
// Synchronous-read data memory with selectable read-during-write behaviour and a
// zero-fill sequencer that clears the array after reset or on request.
module dat_mem_sync #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 8,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_req_i,
    input  logic          wr_en_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] dat_in_i,
    output logic [DW-1:0] dat_out_o,
    output logic          rd_valid_o,
    output logic          busy_o
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic {
        StClear,
        StReady
    } state_e;

    state_e        state_q;
    logic [AW-1:0] clr_ptr_q;
    logic [DW-1:0] dat_out_q;
    logic          rd_valid_q;

    logic [DW-1:0] core [Depth];

    logic          accept;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rd_data;

    // A clear request in READY swallows any access presented in the same cycle.
    always_comb begin
        accept    = (state_q == StReady) && !clr_req_i;
        mem_we    = (state_q == StClear) || (accept && wr_en_i);
        mem_addr  = (state_q == StClear) ? clr_ptr_q : addr_i;
        mem_wdata = (state_q == StClear) ? '0 : dat_in_i;
        rd_data   = ((RDW_MODE != 0) && wr_en_i) ? dat_in_i : core[addr_i];
    end

    // Array contents are deliberately left out of reset; the fill clears them.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            core[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StClear;
            clr_ptr_q  <= '0;
            dat_out_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    rd_valid_q <= 1'b0;
                    if (clr_ptr_q == '1) begin
                        state_q   <= StReady;
                        clr_ptr_q <= '0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                StReady: begin
                    if (clr_req_i) begin
                        state_q    <= StClear;
                        rd_valid_q <= 1'b0;
                    end else if (rd_en_i) begin
                        dat_out_q  <= rd_data;
                        rd_valid_q <= 1'b1;
                    end else begin
                        rd_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

    assign dat_out_o  = dat_out_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = (state_q == StClear);

endmodule

// File: doc/dat_mem_sync.md
# dat_mem_sync

Parametrised successor to the byte-wide data memory: a single-port-address, synchronous-read data memory with configurable word width and depth, selectable read-during-write behaviour, and a built-in zero-fill sequencer that clears the whole array after reset or on request. It sits in the datapath behind the load/store unit, which must hold requests while `busy` is high and take load data on `rd_valid`.

## Interface

**Parameters**
- `DW`, default 8: data word width in bits.
- `AW`, default 8: address width in bits. Depth is 2**AW words.
- `RDW_MODE`, default 0: read-during-write at the same address. 0 returns the old data; 1 returns the new data (write-through).

**Ports**
- `clk`, input, 1 bit: the only clock. All state updates on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `clr_req`, input, 1 bit: single-cycle request to re-run the zero-fill. Sampled only in READY.
- `wr_en`, input, 1 bit: write enable.
- `rd_en`, input, 1 bit: read enable.
- `addr`, input, AW bits: word address, shared by read and write.
- `dat_in`, input, DW bits: write data.
- `dat_out`, output, DW bits: registered read data.
- `rd_valid`, output, 1 bit: `dat_out` holds the data from the read accepted on the previous edge.
- `busy`, output, 1 bit: zero-fill in progress. All requests are ignored while it is high.

## Operation

**State machine**
- Two states, CLEAR and READY.
- Reset puts the FSM in CLEAR with `clr_ptr` = 0.

**CLEAR**
- Each edge writes 0 to `core[clr_ptr]`, then increments `clr_ptr`.
- The edge that writes address 2**AW-1 moves the FSM to READY and returns `clr_ptr` to 0.
- `wr_en`, `rd_en` and `clr_req` are ignored; memory is never written from `dat_in` in this state.

**READY**
- `clr_req` = 1 moves the FSM to CLEAR and takes priority over the other inputs. Any `wr_en` or `rd_en` in that same cycle is dropped.
- `wr_en` = 1: `core[addr]` <= `dat_in`.
- `rd_en` = 1: `dat_out` <= `core[addr]` and `rd_valid` <= 1.
- `rd_en` = 0: `rd_valid` <= 0 and `dat_out` holds its last value.
- `wr_en` and `rd_en` together at the same address: `dat_out` gets old data when `RDW_MODE` = 0, or `dat_in` when `RDW_MODE` = 1.

**Output rules**
- `busy` is combinational from state: high when the FSM is in CLEAR.
- `rd_valid` is 0 whenever the FSM was in CLEAR on the previous edge.

**Width and range**
- Address space is exactly 2**AW, so there are no out-of-range addresses.
- `clr_ptr` is AW bits wide; the transition is decoded at all-ones, never from pointer wrap.

## Timing

**Reset values** (asynchronous, immediate)
- `dat_out` = 0, `rd_valid` = 0, `busy` = 1, state = CLEAR, `clr_ptr` = 0.
- Array contents are not reset directly; they are cleared by the fill.

**Fill timing**
- The fill takes exactly 2**AW edges after `reset` deasserts.
- `busy` falls after edge 2**AW, which is 256 edges for the default parameters.
- Reset asserted mid-fill restarts the fill from address 0.
- `clr_req` behaves the same: the fill completes 2**AW edges after the edge that sampled it.

**Latency and throughput**
- Read latency is 1 edge: address presented before edge N gives data and `rd_valid` after edge N.
- Write takes effect at the edge. A read at the same address on the next cycle returns the new value.
- Back-to-back reads and writes are accepted every cycle in READY with no bubbles.

## Test plan

1. **Reset fill:** assert `reset`, release it, then count edges. Expect `busy` = 1 for exactly 256 edges and a read of addresses 0, 127 and 255 to return 0x00 with `rd_valid` = 1 one edge later.
2. **Write/read:** write 0xA5 to 0x10 and 0x3C to 0xFF, then read both. Expect 0xA5 then 0x3C on consecutive cycles. When `rd_en` drops, `rd_valid` goes to 0 and `dat_out` holds 0x3C.
3. **Read-during-write:** 0x20 holds 0x11; in one cycle write 0x22 to 0x20 and read 0x20. Expect 0x11 when `RDW_MODE` = 0 and 0x22 when `RDW_MODE` = 1. A follow-up read returns 0x22 in both modes.
4. **Clear request:** fill memory with non-zero data, pulse `clr_req` together with `wr_en` to address 0x05 with 0x77. Expect the write dropped, `busy` high for 256 edges, and every address reading 0x00 afterwards.
5. **Reset mid-fill and ignored requests:** during the fill, at `clr_ptr` = 100, assert `wr_en` and `rd_en`. Expect no write and `rd_valid` = 0. Then assert `reset`: all outputs go to reset values immediately, and after release `busy` lasts a full 256 edges.
6. **Parameter sweep:** `DW` = 32, `AW` = 4. Expect `busy` for 16 edges, and a write of 0xDEADBEEF to address 15 followed by a read returns 0xDEADBEEF.
